rvsteel_wdt: RTL and testbench

Watchdog timer peripheral for the RISC-V Steel SoC, attached to the system bus as an additional managed device (32-byte region, base 0x8004_0000). It sits beside the processor core: software must periodically write a key to reload a down-counter; if the counter expires, the block drives a timed reset pulse back into the SoC reset tree and can raise an early-warning interrupt on a fast IRQ line.

---
 rtl/rvsteel_wdt.sv | 229 ++++++++++++++++++++++
 tb/tb_rvsteel_wdt.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_wdt.sv
// rvsteel_wdt: bus-mapped watchdog with a reloadable down-counter, warning IRQ and timed reset pulse.
// Defining RVSTEEL_WDT_LOCK_EN adds the sticky CTRL.LOCK bit.
module rvsteel_wdt #(
  parameter int unsigned RESET_PULSE_CYCLES = 16,
  parameter logic [31:0] DEFAULT_LOAD       = 32'h02FA_F080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic        wdt_reset,
  output logic        irq
);

  localparam int unsigned PW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_LOAD   = 5'h04;
  localparam logic [4:0] ADDR_COUNT  = 5'h08;
  localparam logic [4:0] ADDR_KICK   = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_WARN   = 5'h14;

  localparam logic [31:0] KICK_KEY = 32'h5A5A_A5A5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_WARNED = 2'd2,
    S_FIRE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     load_q, load_d;
  logic [31:0]     warn_q, warn_d;
  logic            en_q, en_d;
  logic            irq_en_q, irq_en_d;
  logic            lock_q, lock_d;
  logic            status_warn_q, status_warn_d;
  logic            status_fired_q, status_fired_d;
  logic [PW-1:0]   pulse_q, pulse_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            read_response_q, read_response_d;
  logic            write_response_q, write_response_d;
  logic            wdt_reset_q, wdt_reset_d;
  logic            irq_q, irq_d;

  logic            full_strobe;
  logic            ctrl_wr, kick_wr, load_wr, warn_wr, status_wr;
  logic            wr_en_bit, wr_irq_en_bit, wr_lock_bit;
  logic            warn_hit;
  logic [31:0]     load_merged, warn_merged;
  logic [31:0]     read_mux;

  // Byte-lane merge for the strobe-honouring registers
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign load_merged[gi*8 +: 8] = write_strobe[gi] ? write_data[gi*8 +: 8] : load_q[gi*8 +: 8];
      assign warn_merged[gi*8 +: 8] = write_strobe[gi] ? write_data[gi*8 +: 8] : warn_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    full_strobe   = (write_strobe == 4'b1111);
    ctrl_wr       = write_request && full_strobe && (rw_address == ADDR_CTRL);
    kick_wr       = write_request && full_strobe && (rw_address == ADDR_KICK);
    load_wr       = write_request && (rw_address == ADDR_LOAD);
    warn_wr       = write_request && (rw_address == ADDR_WARN);
    status_wr     = write_request && write_strobe[0] && (rw_address == ADDR_STATUS);
    wr_en_bit     = write_data[0];
    wr_irq_en_bit = write_data[1];
`ifdef RVSTEEL_WDT_LOCK_EN
    wr_lock_bit   = write_data[2];
`else
    wr_lock_bit   = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    lock_d   = lock_q;
    pulse_d  = pulse_q;
    warn_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr) begin
          en_d     = wr_en_bit;
          irq_en_d = wr_irq_en_bit;
          lock_d   = lock_q | wr_lock_bit;
          if (wr_en_bit) begin
            count_d = load_q;
            state_d = S_RUN;
          end
        end
      end
      S_RUN, S_WARNED: begin
        // Expiry takes priority over a threshold match at zero
        if (count_q == 32'd0) begin
          state_d = S_FIRE;
        end else begin
          count_d = count_q - 32'd1;
          if ((state_q == S_RUN) && (count_q == warn_q)) begin
            warn_hit = 1'b1;
            state_d  = S_WARNED;
          end
        end
        if (ctrl_wr && (wr_en_bit || !lock_q)) begin
          en_d     = wr_en_bit;
          irq_en_d = wr_irq_en_bit;
          lock_d   = lock_q | wr_lock_bit;
          if (!wr_en_bit) begin
            count_d  = count_q;
            warn_hit = 1'b0;
            state_d  = S_IDLE;
          end
        end
        // A kick overrides whatever the countdown decided on this edge
        if (kick_wr) begin
          warn_hit = 1'b0;
          if (write_data == KICK_KEY) begin
            count_d = load_q;
            state_d = S_RUN;
          end else begin
            count_d = count_q;
            state_d = S_FIRE;
          end
        end
      end
      S_FIRE: begin
        if (pulse_q == '0) begin
          if (lock_q) begin
            count_d = load_q;
            state_d = S_RUN;
          end else begin
            en_d    = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          pulse_d = pulse_q - PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d == S_FIRE) && (state_q != S_FIRE)) begin
      pulse_d = PULSE_LAST;
    end
  end

  always_comb begin
    read_mux = 32'd0;
    case (rw_address)
      ADDR_CTRL:   read_mux = {29'd0, lock_q, irq_en_q, en_q};
      ADDR_LOAD:   read_mux = load_q;
      ADDR_COUNT:  read_mux = count_q;
      ADDR_STATUS: read_mux = {30'd0, status_fired_q, status_warn_q};
      ADDR_WARN:   read_mux = warn_q;
      default:     read_mux = 32'd0;
    endcase
  end

  always_comb begin
    load_d           = load_wr ? load_merged : load_q;
    warn_d           = warn_wr ? warn_merged : warn_q;
    // A fresh match wins over a simultaneous write-1-to-clear
    status_warn_d    = warn_hit | (status_warn_q & ~(status_wr & write_data[0]));
    status_fired_d   = ((state_d == S_FIRE) && (state_q != S_FIRE))
                     | (status_fired_q & ~(status_wr & write_data[1]));
    read_data_d      = read_request ? read_mux : 32'd0;
    read_response_d  = read_request;
    write_response_d = write_request;
    wdt_reset_d      = (state_d == S_FIRE);
    irq_d            = status_warn_d & irq_en_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      count_q          <= 32'd0;
      load_q           <= DEFAULT_LOAD;
      warn_q           <= 32'd0;
      en_q             <= 1'b0;
      irq_en_q         <= 1'b0;
      lock_q           <= 1'b0;
      status_warn_q    <= 1'b0;
      status_fired_q   <= 1'b0;
      pulse_q          <= '0;
      read_data_q      <= 32'd0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      wdt_reset_q      <= 1'b0;
      irq_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      load_q           <= load_d;
      warn_q           <= warn_d;
      en_q             <= en_d;
      irq_en_q         <= irq_en_d;
      lock_q           <= lock_d;
      status_warn_q    <= status_warn_d;
      status_fired_q   <= status_fired_d;
      pulse_q          <= pulse_d;
      read_data_q      <= read_data_d;
      read_response_q  <= read_response_d;
      write_response_q <= write_response_d;
      wdt_reset_q      <= wdt_reset_d;
      irq_q            <= irq_d;
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_response_q;
  assign write_response = write_response_q;
  assign wdt_reset      = wdt_reset_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_rvsteel_wdt.sv
// Self-checking bench for rvsteel_wdt: randomized scenarios checked against expectations
// computed from cycle arithmetic on the watchdog's timing rules.
module tb_rvsteel_wdt;

  localparam int          PULSE    = 16;
  localparam logic [31:0] DEF_LOAD = 32'h02FA_F080;
  localparam logic [31:0] KEY      = 32'h5A5A_A5A5;
  localparam logic [4:0]  A_CTRL   = 5'h00;
  localparam logic [4:0]  A_LOAD   = 5'h04;
  localparam logic [4:0]  A_COUNT  = 5'h08;
  localparam logic [4:0]  A_KICK   = 5'h0C;
  localparam logic [4:0]  A_STATUS = 5'h10;
  localparam logic [4:0]  A_WARN   = 5'h14;
  localparam logic [3:0]  FULL     = 4'b1111;

  logic        clock, reset;
  logic [4:0]  rw_address;
  logic [31:0] read_data, write_data;
  logic        read_request, read_response;
  logic [3:0]  write_strobe;
  logic        write_request, write_response;
  logic        wdt_reset, irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  rvsteel_wdt #(
    .RESET_PULSE_CYCLES(PULSE),
    .DEFAULT_LOAD      (DEF_LOAD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rw_address    (rw_address),
    .read_data     (read_data),
    .read_request  (read_request),
    .read_response (read_response),
    .write_data    (write_data),
    .write_strobe  (write_strobe),
    .write_request (write_request),
    .write_response(write_response),
    .wdt_reset     (wdt_reset),
    .irq           (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Bus helpers: called at a negedge, the request is sampled by the following posedge,
  // and the task returns at the next negedge holding the response of that edge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic resp);
    rw_address = a; write_data = d; write_strobe = s; write_request = 1'b1;
    @(negedge clock);
    resp = write_response;
    write_request = 1'b0; write_strobe = 4'h0; write_data = 32'd0;
    $display("[%0d] WR addr=%02h data=%08h strb=%b resp=%b", cyc, a, d, s, resp);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic resp);
    rw_address = a; read_request = 1'b1;
    @(negedge clock);
    d = read_data; resp = read_response;
    read_request = 1'b0;
    $display("[%0d] RD addr=%02h data=%08h resp=%b", cyc, a, d, resp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Waits until the selected output (0: wdt_reset, 1: irq) shows level; n = negedges waited, -1 on timeout
  task automatic wait_sig(input int sel, input logic level, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clock);
      n++;
      if (((sel == 0) ? wdt_reset : irq) === level) return;
    end
    n = -1;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [8] = '{A_CTRL, A_LOAD, A_COUNT, A_KICK, A_STATUS, A_WARN, 5'h18, 5'h1C};
    logic [31:0] exps  [8] = '{32'd0, DEF_LOAD, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] d;
    logic        r;
    checks++;
    if ({read_data, read_response, write_response, wdt_reset, irq} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h rr=%b wr=%b wdt=%b irq=%b expected all 0",
               read_data, read_response, write_response, wdt_reset, irq);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(addrs[i], d, r);
      checks++;
      if (d !== exps[i] || r !== 1'b1) begin
        errors++;
        $display("FAIL reset_reg_%02h: got %h resp=%b expected %h resp=1", addrs[i], d, r, exps[i]);
      end
    end
    @(negedge clock);
    checks++;
    if (read_data !== 32'd0 || read_response !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: got %h resp=%b expected 0 resp=0", read_data, read_response);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, d0, d1;
    logic        r0, r1, r2, r3;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      bus_write(A_LOAD, a, FULL, r0);
      bus_write(A_WARN, b, FULL, r1);
      bus_read(A_LOAD, d0, r2);
      bus_read(A_WARN, d1, r3);
      checks++;
      if ({r0, r1, r2, r3} !== 4'b1111 || d0 !== a || d1 !== b) begin
        errors++;
        $display("FAIL back_to_back: got resp=%b%b%b%b load=%h warn=%h expected 1111 load=%h warn=%h",
                 r0, r1, r2, r3, d0, d1, a, b);
      end
    end
  endtask

  task automatic test_strobe_regs();
    logic [31:0] base, nv, expv, d;
    logic [3:0]  s;
    logic        r;
    for (int i = 0; i < 6; i++) begin
      logic [4:0] a;
      a    = (i % 2 == 0) ? A_LOAD : A_WARN;
      base = $urandom; nv = $urandom; s = 4'($urandom_range(0, 15));
      expv = base;
      for (int k = 0; k < 4; k++) if (s[k]) expv[k*8 +: 8] = nv[k*8 +: 8];
      bus_write(a, base, FULL, r);
      bus_write(a, nv, s, r);
      bus_read(a, d, r);
      checks++;
      if (d !== expv) begin
        errors++;
        $display("FAIL strobe_merge_%02h: got %h expected %h (strb=%b)", a, d, expv, s);
      end
    end
  endtask

  task automatic test_expiry();
    int          n, lat, wid;
    logic [31:0] d;
    logic        r;
    bus_write(A_STATUS, 32'h3, FULL, r);
    bus_write(A_WARN, 32'd0, FULL, r);
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 10 : int'($urandom_range(0, 40));
      bus_write(A_LOAD, 32'(n), FULL, r);
      bus_write(A_CTRL, 32'h1, FULL, r);
      wait_sig(0, 1'b1, n + 60, lat);
      checks++;
      if (lat !== n + 1) begin
        errors++;
        $display("FAIL expiry_latency: got %0d cycles expected %0d (load=%0d)", lat, n + 1, n);
      end
      wait_sig(0, 1'b0, PULSE + 40, wid);
      checks++;
      if (wid !== PULSE) begin
        errors++;
        $display("FAIL pulse_width: got %0d expected %0d", wid, PULSE);
      end
      bus_read(A_STATUS, d, r);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL expiry_status: got %h expected 2", d); end
      bus_read(A_CTRL, d, r);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL expiry_ctrl: got %h expected 0", d); end
      bus_read(A_COUNT, d, r);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL expiry_count: got %h expected 0", d); end
      bus_write(A_STATUS, 32'h2, FULL, r);
      bus_read(A_STATUS, d, r);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL fired_w1c: got %h expected 0", d); end
    end
  endtask

  task automatic test_warn_kick();
    int          l, w, lat;
    logic [31:0] d;
    logic        r;
    for (int it = 0; it < 3; it++) begin
      l = (it == 0) ? 100 : int'($urandom_range(60, 150));
      w = (it == 0) ? 40 : int'($urandom_range(5, l - 15));
      bus_write(A_STATUS, 32'h3, FULL, r);
      bus_write(A_LOAD, 32'(l), FULL, r);
      bus_write(A_WARN, 32'(w), FULL, r);
      bus_write(A_CTRL, 32'h3, FULL, r);
      wait_sig(1, 1'b1, l + 10, lat);
      checks++;
      if (lat !== l - w + 1) begin
        errors++;
        $display("FAIL irq_latency: got %0d expected %0d (load=%0d warn=%0d)", lat, l - w + 1, l, w);
      end
      bus_read(A_COUNT, d, r);
      checks++;
      if (d !== 32'(w - 1)) begin errors++; $display("FAIL count_after_warn: got %0d expected %0d", d, w - 1); end
      bus_write(A_KICK, KEY, FULL, r);
      bus_read(A_COUNT, d, r);
      checks++;
      if (d !== 32'(l) || irq !== 1'b1) begin
        errors++;
        $display("FAIL kick_reload: got count=%0d irq=%b expected count=%0d irq=1", d, irq, l);
      end
      bus_read(A_STATUS, d, r);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL warn_status: got %h expected 1", d); end
      bus_write(A_STATUS, 32'h1, FULL, r);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
      bus_write(A_CTRL, 32'h0, FULL, r);
    end
  endtask

  task automatic test_partial_badkey();
    int          l, e0, wid;
    logic [31:0] d, expv;
    logic        r;
    l = int'($urandom_range(40, 80));
    bus_write(A_STATUS, 32'h3, FULL, r);
    bus_write(A_WARN, 32'd0, FULL, r);
    bus_write(A_LOAD, 32'(l), FULL, r);
    bus_write(A_CTRL, 32'h1, FULL, r);
    e0 = cyc;
    bus_write(A_KICK, KEY, 4'b0011, r);
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL partial_kick_resp: got %b expected 1", r); end
    bus_write(A_CTRL, 32'h0, 4'b0001, r);
    bus_read(A_COUNT, d, r);
    expv = 32'(l - (cyc - 1 - e0));
    checks++;
    if (d !== expv) begin errors++; $display("FAIL partial_ignored_count: got %0d expected %0d", d, expv); end
    bus_read(A_CTRL, d, r);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL partial_ctrl_ignored: got %h expected 1", d); end
    bus_write(A_KICK, 32'h1234_5678, FULL, r);
    checks++;
    if (wdt_reset !== 1'b1) begin errors++; $display("FAIL bad_key_fire: got %b expected 1", wdt_reset); end
    wait_sig(0, 1'b0, PULSE + 40, wid);
    checks++;
    if (wid !== PULSE) begin errors++; $display("FAIL bad_key_pulse: got %0d expected %0d", wid, PULSE); end
    bus_write(A_STATUS, 32'h3, FULL, r);
  endtask

  task automatic test_boundary();
    int          n, l, w, lat, wid;
    logic [31:0] d;
    logic        r;
    // Valid kick on the edge where COUNT would go 1 -> 0
    n = int'($urandom_range(2, 20));
    bus_write(A_WARN, 32'd0, FULL, r);
    bus_write(A_LOAD, 32'(n), FULL, r);
    bus_write(A_CTRL, 32'h1, FULL, r);
    idle(n - 1);
    bus_write(A_KICK, KEY, FULL, r);
    checks++;
    if (wdt_reset !== 1'b0) begin errors++; $display("FAIL last_cycle_kick: got wdt_reset=%b expected 0", wdt_reset); end
    bus_read(A_COUNT, d, r);
    checks++;
    if (d !== 32'(n)) begin errors++; $display("FAIL last_cycle_reload: got %0d expected %0d", d, n); end
    wait_sig(0, 1'b1, n + 30, lat);
    checks++;
    if (lat !== n) begin errors++; $display("FAIL refire_latency: got %0d expected %0d", lat, n); end
    wait_sig(0, 1'b0, PULSE + 40, wid);
    // WARN == 0: expiry wins, no warning raised
    bus_write(A_STATUS, 32'h3, FULL, r);
    bus_write(A_CTRL, 32'h3, FULL, r);
    wait_sig(0, 1'b1, n + 30, lat);
    wait_sig(0, 1'b0, PULSE + 40, wid);
    bus_read(A_STATUS, d, r);
    checks++;
    if (d !== 32'h2 || irq !== 1'b0) begin
      errors++;
      $display("FAIL warn_zero_priority: got status=%h irq=%b expected status=2 irq=0", d, irq);
    end
    // Clear of WARN on the very edge of a new match
    l = int'($urandom_range(20, 40));
    w = int'($urandom_range(3, l - 5));
    bus_write(A_STATUS, 32'h3, FULL, r);
    bus_write(A_WARN, 32'(w), FULL, r);
    bus_write(A_LOAD, 32'(l), FULL, r);
    bus_write(A_CTRL, 32'h3, FULL, r);
    idle(l - w);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_match: got %b expected 0", irq); end
    bus_write(A_STATUS, 32'h1, FULL, r);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL w1c_vs_match: got irq=%b expected 1", irq); end
    bus_write(A_STATUS, 32'h1, FULL, r);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_after_match: got irq=%b expected 0", irq); end
    bus_write(A_CTRL, 32'h0, FULL, r);
  endtask

  task automatic test_lock();
    int          l, e0;
    logic [31:0] d, expv;
    logic        r;
    l = 30;
    bus_write(A_STATUS, 32'h3, FULL, r);
    bus_write(A_WARN, 32'd0, FULL, r);
    bus_write(A_LOAD, 32'(l), FULL, r);
    bus_write(A_CTRL, 32'h5, FULL, r);
    e0 = cyc;
    bus_read(A_CTRL, d, r);
`ifdef RVSTEEL_WDT_LOCK_EN
    expv = 32'h5;
`else
    expv = 32'h1;
`endif
    checks++;
    if (d !== expv) begin errors++; $display("FAIL lock_ctrl_read: got %h expected %h", d, expv); end
    bus_write(A_CTRL, 32'h0, FULL, r);
    bus_read(A_CTRL, d, r);
`ifdef RVSTEEL_WDT_LOCK_EN
    expv = 32'h5;
`else
    expv = 32'h0;
`endif
    checks++;
    if (d !== expv) begin errors++; $display("FAIL lock_disable_ctrl: got %h expected %h", d, expv); end
    bus_read(A_COUNT, d, r);
`ifdef RVSTEEL_WDT_LOCK_EN
    expv = 32'(l - (cyc - 1 - e0));
`else
    expv = 32'(l - 1);
`endif
    checks++;
    if (d !== expv) begin errors++; $display("FAIL lock_disable_count: got %0d expected %0d", d, expv); end
`ifdef RVSTEEL_WDT_LOCK_EN
    begin
      int lat, wid;
      wait_sig(0, 1'b1, l + 40, lat);
      wait_sig(0, 1'b0, PULSE + 40, wid);
      checks++;
      if (wid !== PULSE) begin errors++; $display("FAIL lock_pulse: got %0d expected %0d", wid, PULSE); end
      bus_read(A_COUNT, d, r);
      checks++;
      if (d !== 32'(l)) begin errors++; $display("FAIL lock_reload: got %0d expected %0d", d, l); end
      bus_read(A_COUNT, d, r);
      checks++;
      if (d !== 32'(l - 1)) begin errors++; $display("FAIL lock_continues: got %0d expected %0d", d, l - 1); end
    end
`else
    bus_read(A_COUNT, d, r);
    checks++;
    if (d !== 32'(l - 1)) begin errors++; $display("FAIL nolock_stopped: got %0d expected %0d", d, l - 1); end
`endif
  endtask

  task automatic test_reset_mid_pulse();
    int          lat;
    logic [31:0] d;
    logic        r;
    bus_write(A_LOAD, 32'd3, FULL, r);
    bus_write(A_CTRL, 32'h1, FULL, r);
    wait_sig(0, 1'b1, 200, lat);
    checks++;
    if (lat < 1) begin errors++; $display("FAIL reset_test_fire: got timeout expected wdt_reset high"); end
    idle(3);
    reset = 1'b0;
    #1;
    checks++;
    if (wdt_reset !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got wdt_reset=%b irq=%b expected 0 0", wdt_reset, irq);
    end
    @(negedge clock);
    reset = 1'b1;
    bus_read(A_LOAD, d, r);
    checks++;
    if (d !== DEF_LOAD) begin errors++; $display("FAIL reset_load: got %h expected %h", d, DEF_LOAD); end
    bus_read(A_CTRL, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    bus_read(A_STATUS, d, r);
    checks++;
    if (d !== 32'h0 || wdt_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got %h wdt_reset=%b expected 0 0", d, wdt_reset);
    end
  endtask

  initial begin
    reset = 1'b0; read_request = 1'b0; write_request = 1'b0;
    rw_address = 5'd0; write_data = 32'd0; write_strobe = 4'd0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    test_reset();
    test_back_to_back();
    test_strobe_regs();
    test_expiry();
    test_warn_kick();
    test_partial_badkey();
    test_boundary();
    test_lock();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
